// File: rtl/reg8file_arbiter.sv
// Two-master round-robin arbiter and zeroing sweep for an 8 x DW register file; owns all rf_* pins.
// Latency: grant is combinational (0 cycles), rvalid/rdata 1 cycle after a read grant; backpressure: req is held until gnt.
module reg8file_arbiter #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          soft_clr,
   output logic          busy,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [DW-1:0] rf_d,
   output logic          rf_en,
   output logic [AW-1:0] rf_wsel,
   output logic [AW-1:0] rf_rsel,
   output logic          rf_clr,
   input  logic [DW-1:0] rf_q
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [AW-1:0] CNT_MAX = '1;

   state_t        state;
   logic [AW-1:0] cnt;
   logic          ptr;
   logic [AW-1:0] rsel_q;
   logic          run_ok;

   assign rf_clr = 1'b0;
   assign run_ok = clr_n && (state == RUN) && !soft_clr;

   // ptr names the master that wins a tie; a lone requester always wins
   always_comb begin
      gnt0    = run_ok & req0 & (~req1 | ~ptr);
      gnt1    = run_ok & req1 & (~req0 | ptr);
      busy    = ~clr_n | (state == INIT);
      rf_en   = 1'b0;
      rf_wsel = '0;
      rf_d    = '0;
      rf_rsel = rsel_q;
      if (clr_n && state == INIT) begin
         rf_en   = 1'b1;
         rf_wsel = cnt;
      end else if (gnt0) begin
         if (we0) begin
            rf_en   = 1'b1;
            rf_wsel = addr0;
            rf_d    = wdata0;
         end else begin
            rf_rsel = addr0;
         end
      end else if (gnt1) begin
         if (we1) begin
            rf_en   = 1'b1;
            rf_wsel = addr1;
            rf_d    = wdata1;
         end else begin
            rf_rsel = addr1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state   <= INIT;
         cnt     <= '0;
         ptr     <= 1'b0;
         rsel_q  <= '0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rsel_q  <= rf_rsel;
         rvalid0 <= gnt0 & ~we0;
         rvalid1 <= gnt1 & ~we1;
         if (gnt0 && !we0) rdata0 <= rf_q;
         if (gnt1 && !we1) rdata1 <= rf_q;
         if (state == INIT) begin
            if (soft_clr) begin
               cnt <= '0;
            end else if (cnt == CNT_MAX) begin
               cnt   <= '0;
               state <= RUN;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            if (soft_clr) begin
               state <= INIT;
               cnt   <= '0;
            end else if (gnt0) begin
               ptr <= 1'b1;
            end else if (gnt1) begin
               ptr <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/reg8file_arbiter.md
# reg8file_arbiter

Two-port access arbiter and initialisation sequencer for one 8 x 8-bit register file (`d`, `clk`, `clr`, `en`, `wsel`, `rsel`, `q`). It sits between two requesting masters and the register file, sharing its single write port and single read port by round-robin arbitration. After reset, or on `soft_clr`, it zeroes every register by sweeping the write port. It owns all register-file control pins.

## Interface
- `DW`, default 8: data width; matches register-file `d`/`q`.
- `AW`, default 3: address width; matches `wsel`/`rsel`. Register count NREG = 2**AW.

Ports:
- `clk`  in  1  rising-edge clock.
- `clr_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `soft_clr`  in  1  request re-initialisation sweep.
- `busy`  out  1  high while sweeping (INIT state).
- `req0`, `req1`  in  1 each  master request, held until granted.
- `we0`, `we1`  in  1 each  1 = write, 0 = read.
- `addr0`, `addr1`  in  AW each  register address.
- `wdata0`, `wdata1`  in  DW each  write data.
- `gnt0`, `gnt1`  out  1 each  grant. Combinational; the transfer completes at the edge where gnt is high.
- `rvalid0`, `rvalid1`  out  1 each  read data valid, registered.
- `rdata0`, `rdata1`  out  DW each  read data, registered and held until the next read for that master.
- `rf_d`  out  DW  to register file `d`.
- `rf_en`  out  1  to register file `en` (write enable).
- `rf_wsel`  out  AW  to register file `wsel`.
- `rf_rsel`  out  AW  to register file `rsel`.
- `rf_clr`  out  1  to register file `clr`. Tied 0; clearing is done by the sweep.
- `rf_q`  in  DW  from register file `q`. Combinational in `rsel`.

## Operation
- FSM has two states: INIT and RUN.
- **INIT**
  - Counter `cnt` (AW bits) drives `rf_wsel = cnt`, `rf_d = 0`, `rf_en = 1`.
  - `cnt` increments each cycle.
  - When `cnt == NREG-1`, the next state is RUN and `cnt` returns to 0.
  - No grants; `busy = 1`.
- **RUN**
  - `busy = 0`.
  - Each cycle at most one master is granted.
  - Round-robin pointer `ptr` (1 bit; 0 means master0 has priority):
    - Both requesting: grant master `ptr`, then `ptr <=` the other master.
    - One requesting: grant it, then `ptr <=` the other master.
    - Neither requesting: no grant, `ptr` unchanged.
  - Granted write: `rf_en = 1`, `rf_wsel = addrN`, `rf_d = wdataN`. The register updates at that edge.
  - Granted read: `rf_rsel = addrN`. `rdataN <= rf_q` at that edge, and `rvalidN = 1` for exactly the following cycle.
  - No grant or a read grant: `rf_en = 0`.
  - `rf_rsel` holds its last value when there is no read grant. `rf_wsel` and `rf_d` are don't-care when `rf_en = 0`; drive 0.
- **soft_clr**
  - Sampled high in RUN: no grant that cycle; next state INIT with `cnt = 0`.
  - Sampled high in INIT: `cnt` restarts at 0.
  - A read granted in the cycle before `soft_clr` still returns its `rvalid` and `rdata`.
- Read-after-write to the same address on consecutive grants returns the new value, because the write commits at the edge before the read's cycle.

## Timing
- Reset (`clr_n = 0` at an edge):
  - State INIT, `cnt = 0`, `ptr = 0`.
  - `rvalid0`/`rvalid1` = 0, `rdata0`/`rdata1` = 0, `rf_rsel = 0`.
  - Combinational outputs during reset: `gnt0`/`gnt1` = 0, `rf_en = 0`, `busy = 1`.
- Reset takes effect mid-sweep or mid-RUN at the next edge; any pending `rvalid` is cancelled.
- The sweep occupies NREG cycles after `clr_n` rises (8 for the defaults). The first grant is possible in cycle NREG.
- Grant latency: 0 cycles (same cycle as `req` when in RUN and priority allows).
- Worst-case wait under contention: 1 cycle.
- Read latency: `rvalid` 1 cycle after `gnt`.
- Write commit: at the grant edge.
- Back-to-back grants to the same master are allowed when the other master is idle, giving a throughput of 1 transfer per cycle.

## Test plan
- **Reset then sweep:** preload all registers with 0xFF, pulse `clr_n` low, hold `req0 = 1`.
  - `busy` high for 8 cycles; `rf_en = 1` with `rf_wsel` 0..7 and `rf_d = 0`; `gnt0 = 0` throughout.
  - `gnt0` first rises in cycle 8.
- **Single-master write/read:** master0 writes 0x01..0x80 to addresses 0..7, then reads 0..7.
  - `gnt0` every cycle.
  - `rdata0` = 0x01, 0x02, ..., 0x80, each with `rvalid0` one cycle after its grant.
- **Contention:** `req0` and `req1` held continuously with reads.
  - Grants alternate 0, 1, 0, 1 starting with master0 after reset.
  - Each `rvalid` appears only on its own port.
- **Read-after-write:** master1 writes 0x5A to address 3, then master0 reads address 3 on the next cycle.
  - `rdata0 = 0x5A`.
- **soft_clr mid-traffic:** after loading address 6 with 0x40, assert `soft_clr` for 1 cycle while `req1` is high.
  - No grant that cycle, then an 8-cycle sweep.
  - A subsequent read of address 6 returns 0x00.
- **Reset during sweep:** drop `clr_n` at `cnt = 4`.
  - Sweep restarts from 0; `busy` is high for a full 8 cycles after release.
